// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad. One column at a time is driven low and the
//   active-low rows are sampled. A press is accepted after DEBOUNCE_SCANS
//   matching ticks, which produces a one-cycle key event. The accepted digit
//   is shifted into a 32-bit entry register that drives the seven-segment
//   display driver's value input.
//
//   Optional feature: define KEYPAD_AUTOREPEAT_EN to re-issue the held key
//   every REPEAT_TICKS ticks. Without it, each press gives exactly one event,
//   and neither REPEAT_TICKS nor a repeat counter exists.
//
// Parameters
//   SCAN_DIV       clk cycles per column dwell. The last cycle of a dwell is a "tick".
//   DEBOUNCE_SCANS consecutive ticks needed to accept a press or a release (>=1)
//   REPEAT_TICKS   ticks between auto-repeat events (KEYPAD_AUTOREPEAT_EN only)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   keypad columns, one-hot active-low
//   clear      synchronous clear of value
//   key_valid  one-cycle pulse per accepted key event
//   key_code   code {row, col} of the last accepted key
//   value      digit entry register, newest digit in [3:0]
module keypad_scanner #(
   parameter int SCAN_DIV       = 16384,
   parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
   ,
   parameter int REPEAT_TICKS   = 32
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   input  logic        clear,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [31:0] value
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RPT_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);
`endif

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   state_t           state;
   logic [3:0]       row_meta;
   logic [3:0]       row_s;
   logic [DIV_W-1:0] div;
   logic [1:0]       c;
   logic [1:0]       r;
   logic [CNT_W-1:0] cnt;       // press count in DEBOUNCE, release count in HELD
`ifdef KEYPAD_AUTOREPEAT_EN
   logic [RPT_W-1:0] rpt;
`endif
   logic             tick;
   logic             any_low;
   logic             accept;
   logic [3:0]       acc_code;

   // When several rows are low at once, the lowest-numbered row wins.
   function automatic logic [1:0] lowest_row(input logic [3:0] rows);
      if (!rows[0])      return 2'd0;
      else if (!rows[1]) return 2'd1;
      else if (!rows[2]) return 2'd2;
      else               return 2'd3;
   endfunction

   assign tick    = (div == DIV_LAST);
   assign any_low = ~&row_s;
   assign col     = ~(4'b0001 << c);

   // An accept happens on a tick. Its result (event pulse, shift) becomes visible in the next cycle.
   always_comb begin
      accept   = 1'b0;
      acc_code = {r, c};
      if (tick) begin
         case (state)
            SCAN: begin
               // With single-tick debounce, the detection tick is also the accepting tick.
               if (any_low && DEBOUNCE_SCANS == 1) begin
                  accept   = 1'b1;
                  acc_code = {lowest_row(row_s), c};
               end
            end
            DEBOUNCE: begin
               if (!row_s[r] && cnt == CNT_LAST) accept = 1'b1;
            end
            HELD: begin
`ifdef KEYPAD_AUTOREPEAT_EN
               if (!row_s[r] && rpt == RPT_LAST) accept = 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta  <= 4'hF;
         row_s     <= 4'hF;
         div       <= '0;
         state     <= SCAN;
         c         <= 2'd0;
         r         <= 2'd0;
         cnt       <= '0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         value     <= 32'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt       <= '0;
`endif
      end else begin
         // stage: two-flop synchronizer for the asynchronous rows
         row_meta <= row;
         row_s    <= row_meta;

         div       <= tick ? '0 : div + 1'b1;
         key_valid <= accept;
         if (accept) key_code <= acc_code;

         // A clear in the same cycle as an accept leaves only the new digit.
         if (accept)     value <= {(clear ? 28'h0 : value[27:0]), acc_code};
         else if (clear) value <= 32'h0;

         if (tick) begin
            case (state)
               SCAN: begin
                  if (any_low) begin
                     r <= lowest_row(row_s);
                     if (DEBOUNCE_SCANS == 1) begin
                        state <= HELD;
                        cnt   <= '0;
                     end else begin
                        state <= DEBOUNCE;
                        cnt   <= CNT_W'(1);
                     end
                  end else begin
                     c <= c + 2'd1;
                  end
               end
               DEBOUNCE: begin
                  if (!row_s[r]) begin
                     if (cnt == CNT_LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else begin
                     state <= SCAN;
                     cnt   <= '0;
                     c     <= c + 2'd1;
                  end
               end
               HELD: begin
                  // Release requires all rows high, so other keys in the column keep us here.
                  if (any_low) begin
                     cnt <= '0;
                  end else if (cnt == CNT_LAST) begin
                     state <= SCAN;
                     cnt   <= '0;
                     c     <= c + 2'd1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= SCAN;
            endcase
`ifdef KEYPAD_AUTOREPEAT_EN
            // Kept at zero outside HELD, so entering HELD starts a fresh repeat interval.
            if (state != HELD || row_s[r] || rpt == RPT_LAST) rpt <= '0;
            else                                              rpt <= rpt + 1'b1;
`endif
         end
      end
   end

endmodule
